limb_master: RTL and testbench

LIMB_MASTER -- requirements
Module: limb_master

---
 rtl/limb_master.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_limb_master.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/limb_master.sv
// LIMB bus master: turns single word read/write commands into LIMB byte cycles.
// Optional address-continuation bursts are compiled in with `define LIMB_MASTER_BURST_EN.
module limb_master #(
    parameter int TIMEOUT = 1024
) (
    input  logic        limb_clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [35:0] cmd_adr,
    input  logic [31:0] cmd_dat,
    output logic        rsp_valid,
    output logic [31:0] rsp_dat,
    output logic        rsp_err,
    output logic [7:0]  limb_d_out,
    output logic        limb_d_oe,
    input  logic [7:0]  limb_d_in,
    output logic        limb_start,
    output logic        limb_nrd,
    input  logic        limb_nwait,
    output logic        limb_sclk_en
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_A0   = 4'd1,
        ST_A1   = 4'd2,
        ST_A2   = 4'd3,
        ST_A3   = 4'd4,
        ST_A4   = 4'd5,
        ST_D0   = 4'd6,
        ST_D1   = 4'd7,
        ST_D2   = 4'd8,
        ST_D3   = 4'd9,
        ST_WAIT = 4'd10,
        ST_R1   = 4'd11,
        ST_R2   = 4'd12,
        ST_R3   = 4'd13,
        ST_R0   = 4'd14,
        ST_DONE = 4'd15
    } state_t;

    state_t             state_q, state_d;
    logic               we_q, we_d;
    logic [35:0]        adr_q, adr_d;
    logic [31:0]        dat_q, dat_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic               sync1_q, sync2_q;
    logic               nwait_s;
    logic               accept_s;
    logic               wait_ok_s;
    logic               wait_to_s;

    assign nwait_s   = sync2_q;
    assign accept_s  = (state_q == ST_IDLE) && cmd_valid;
    // The first two WAIT cycles ignore the slave; a ready slave always wins over timeout.
    assign wait_ok_s = (wait_cnt_q >= CNT_W'(2)) && nwait_s;
    assign wait_to_s = !wait_ok_s && (wait_cnt_q == CNT_W'(TIMEOUT - 1));

`ifdef LIMB_MASTER_BURST_EN
    logic ctx_valid_q, ctx_valid_d;
    logic burst_hit_s;

    // The latched command fields are the previous command, so only a valid bit is kept.
    always_comb begin
        burst_hit_s = ctx_valid_q && (cmd_we == we_q) &&
                      (cmd_adr[35:8] == adr_q[35:8]) &&
                      (adr_q[7:0] != 8'hFF) &&
                      (cmd_adr[7:0] == (adr_q[7:0] + 8'd1));
    end

    // Context is established by a clean response and lost on timeout.
    always_comb begin
        ctx_valid_d = ctx_valid_q;
        if (state_q == ST_DONE && !err_q) begin
            ctx_valid_d = 1'b1;
        end else if (state_q == ST_WAIT && wait_to_s) begin
            ctx_valid_d = 1'b0;
        end else begin
            ctx_valid_d = ctx_valid_q;
        end
    end

    // Burst context register.
    always_ff @(posedge limb_clk) begin
        if (reset) begin
            ctx_valid_q <= 1'b0;
        end else begin
            ctx_valid_q <= ctx_valid_d;
        end
    end
`endif

    // Two-flop synchroniser for the asynchronous wait line.
    always_ff @(posedge limb_clk) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= limb_nwait;
            sync2_q <= sync1_q;
        end
    end

    // State register.
    always_ff @(posedge limb_clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
`ifdef LIMB_MASTER_BURST_EN
                    state_d = burst_hit_s ? ST_D0 : ST_A0;
`else
                    state_d = ST_A0;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_A0:   state_d = ST_A1;
            ST_A1:   state_d = ST_A2;
            ST_A2:   state_d = ST_A3;
            ST_A3:   state_d = ST_A4;
            ST_A4:   state_d = ST_D0;
            ST_D0:   state_d = we_q ? ST_D1 : ST_WAIT;
            ST_D1:   state_d = ST_D2;
            ST_D2:   state_d = ST_D3;
            ST_D3:   state_d = ST_WAIT;
            ST_WAIT: begin
                if (wait_ok_s) begin
                    state_d = we_q ? ST_DONE : ST_R1;
                end else if (wait_to_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_R1:   state_d = ST_R2;
            ST_R2:   state_d = ST_R3;
            ST_R3:   state_d = ST_R0;
            ST_R0:   state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode from the current state.
    always_comb begin
        cmd_ready    = 1'b0;
        limb_start   = 1'b0;
        limb_nrd     = 1'b1;
        limb_d_oe    = 1'b0;
        limb_d_out   = 8'h00;
        limb_sclk_en = 1'b0;
        rsp_valid    = 1'b0;
        rsp_dat      = 32'h0000_0000;
        rsp_err      = 1'b0;
        case (state_q)
            ST_IDLE: cmd_ready = 1'b1;
            ST_A0: begin
                limb_start   = 1'b1;
                limb_d_oe    = 1'b1;
                limb_d_out   = adr_q[7:0];
                limb_sclk_en = 1'b1;
            end
            ST_A1: begin
                limb_d_oe    = 1'b1;
                limb_d_out   = adr_q[15:8];
                limb_sclk_en = 1'b1;
            end
            ST_A2: begin
                limb_d_oe    = 1'b1;
                limb_d_out   = adr_q[23:16];
                limb_sclk_en = 1'b1;
            end
            ST_A3: begin
                limb_d_oe    = 1'b1;
                limb_d_out   = adr_q[31:24];
                limb_sclk_en = 1'b1;
            end
            ST_A4: begin
                limb_d_oe    = 1'b1;
                limb_d_out   = {4'b0000, adr_q[35:32]};
                limb_sclk_en = 1'b1;
            end
            ST_D0: begin
                limb_sclk_en = 1'b1;
                if (we_q) begin
                    limb_d_oe  = 1'b1;
                    limb_d_out = dat_q[7:0];
                end else begin
                    limb_nrd   = 1'b0;
                end
            end
            ST_D1: begin
                limb_d_oe    = 1'b1;
                limb_d_out   = dat_q[15:8];
                limb_sclk_en = 1'b1;
            end
            ST_D2: begin
                limb_d_oe    = 1'b1;
                limb_d_out   = dat_q[23:16];
                limb_sclk_en = 1'b1;
            end
            ST_D3: begin
                limb_d_oe    = 1'b1;
                limb_d_out   = dat_q[31:24];
                limb_sclk_en = 1'b1;
            end
            ST_R1, ST_R2, ST_R3: limb_sclk_en = 1'b1;
            ST_DONE: begin
                rsp_valid = 1'b1;
                rsp_dat   = rdata_q;
                rsp_err   = err_q;
            end
            default: cmd_ready = 1'b0;
        endcase
    end

    // Command latch, read-data assembly and timeout bookkeeping.
    always_comb begin
        we_d    = we_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        if (state_q == ST_WAIT) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end else begin
            wait_cnt_d = '0;
        end
        if (accept_s) begin
            we_d    = cmd_we;
            adr_d   = cmd_adr;
            dat_d   = cmd_dat;
            rdata_d = 32'h0000_0000;
            err_d   = 1'b0;
        end else if (state_q == ST_WAIT && wait_to_s) begin
            err_d   = 1'b1;
        end else begin
            case (state_q)
                ST_R1:   rdata_d[7:0]   = limb_d_in;
                ST_R2:   rdata_d[15:8]  = limb_d_in;
                ST_R3:   rdata_d[23:16] = limb_d_in;
                ST_R0:   rdata_d[31:24] = limb_d_in;
                default: rdata_d        = rdata_q;
            endcase
        end
    end

    // Datapath registers.
    always_ff @(posedge limb_clk) begin
        if (reset) begin
            we_q       <= 1'b0;
            adr_q      <= 36'h0_0000_0000;
            dat_q      <= 32'h0000_0000;
            rdata_q    <= 32'h0000_0000;
            err_q      <= 1'b0;
            wait_cnt_q <= '0;
        end else begin
            we_q       <= we_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

endmodule

// File: tb/tb_limb_master.sv
// Bench for limb_master: directed and random transactions against a cycle-level
// transaction model with a behavioural LIMB slave.
module tb_limb_master;
    localparam int TO = 64;

    logic        limb_clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [35:0] cmd_adr;
    logic [31:0] cmd_dat;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_dat;
    logic [7:0]  limb_d_out, limb_d_in;
    logic        limb_d_oe, limb_start, limb_nrd, limb_nwait, limb_sclk_en;

    int n_assert = 0;
    int n_fail   = 0;

    // Burst context of the model and the staged next command for hold-off tests.
    bit          ctx_valid = 1'b0;
    bit          ctx_we    = 1'b0;
    logic [35:0] ctx_adr   = 36'h0;
    bit          nxt_we;
    logic [35:0] nxt_adr;
    logic [31:0] nxt_dat;

    limb_master #(.TIMEOUT(TO)) dut (
        .limb_clk    (limb_clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_we      (cmd_we),
        .cmd_adr     (cmd_adr),
        .cmd_dat     (cmd_dat),
        .rsp_valid   (rsp_valid),
        .rsp_dat     (rsp_dat),
        .rsp_err     (rsp_err),
        .limb_d_out  (limb_d_out),
        .limb_d_oe   (limb_d_oe),
        .limb_d_in   (limb_d_in),
        .limb_start  (limb_start),
        .limb_nrd    (limb_nrd),
        .limb_nwait  (limb_nwait),
        .limb_sclk_en(limb_sclk_en)
    );

    always #5 limb_clk = ~limb_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check(tag, {cmd_ready, rsp_valid, rsp_err, rsp_dat, limb_start, limb_nrd,
                    limb_d_oe, limb_d_out, limb_sclk_en},
                   {1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0});
    endtask

    // One command: slave holds nwait low nw cycles into WAIT; rst_at>0 resets at that cycle.
    task automatic xact(input bit we, input logic [35:0] adr, input logic [31:0] dat,
                        input logic [31:0] rd, input int nw, input bit keep,
                        input int rst_at, input bit chk_b2b);
        logic [10:0] exp_q[$];
        logic [10:0] got_q[$];
        bit burst, ok, got_rsp;
        int req_len, exp_lat, k, ret, waited, idx;

`ifdef LIMB_MASTER_BURST_EN
        burst = ctx_valid && (we == ctx_we) && (adr[35:8] == ctx_adr[35:8]) &&
                (ctx_adr[7:0] != 8'hFF) && (adr[7:0] == ctx_adr[7:0] + 8'd1);
`else
        burst = 1'b0;
`endif
        // Beat = {start, nrd, oe, data-if-driven}
        if (!burst) begin
            exp_q.push_back({3'b111, adr[7:0]});
            exp_q.push_back({3'b011, adr[15:8]});
            exp_q.push_back({3'b011, adr[23:16]});
            exp_q.push_back({3'b011, adr[31:24]});
            exp_q.push_back({3'b011, 4'h0, adr[35:32]});
        end
        if (we) begin
            for (int i = 0; i < 4; i++) exp_q.push_back({3'b011, dat[8*i +: 8]});
        end else begin
            exp_q.push_back({3'b000, 8'h00});
        end
        req_len = exp_q.size();
        ok = (nw <= TO - 3);
        if (ok && !we) begin
            for (int i = 0; i < 3; i++) exp_q.push_back({3'b010, 8'h00});
        end
        exp_lat = ok ? (req_len + 4 + nw + (we ? 0 : 4)) : (req_len + TO + 1);

        cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_valid = 1'b1;
        limb_nwait = (nw == 0);
        waited = 0;
        while (!(cmd_ready === 1'b1) && waited < 200) begin
            @(negedge limb_clk);
            waited++;
        end
        check("accept", cmd_ready, 1'b1);
        if (chk_b2b) check("b2b_accept_delay", waited, 0);
        if (cmd_ready !== 1'b1) begin
            cmd_valid = 1'b0;
            return;
        end

        k = 0; ret = 0; got_rsp = 1'b0;
        while (!got_rsp && k < req_len + TO + 30) begin
            @(negedge limb_clk);
            k++;
            if (k == 1) begin
                cmd_valid = keep;
                if (keep) begin
                    cmd_we = nxt_we; cmd_adr = nxt_adr; cmd_dat = nxt_dat;
                end
            end
            if (rst_at != 0 && k == rst_at) begin
                reset = 1'b1;
                @(negedge limb_clk);
                check_reset_outputs("reset_mid_xact");
                reset = 1'b0;
                cmd_valid = 1'b0;
                for (int i = 0; i < 20; i++) begin
                    @(negedge limb_clk);
                    check("no_rsp_after_reset", rsp_valid, 1'b0);
                end
                ctx_valid = 1'b0;
                return;
            end
            idx = (ret > 3) ? 3 : ret;
            limb_d_in  = rd[8*idx +: 8];
            limb_nwait = (nw == 0) || (k >= req_len + 1 + nw);
            if (limb_sclk_en === 1'b1) begin
                got_q.push_back({limb_start, limb_nrd, limb_d_oe,
                                 (limb_d_oe === 1'b1) ? limb_d_out : 8'h00});
                if (got_q.size() > req_len) ret++;
            end else begin
                check("quiet_ctl", {limb_start, limb_nrd, limb_d_oe}, 3'b010);
            end
            check("busy_ready", cmd_ready, 1'b0);
            if (rsp_valid === 1'b1) got_rsp = 1'b1;
        end

        check("rsp_seen", got_rsp, 1'b1);
        check("latency", k, exp_lat);
        check("rsp_err", rsp_err, !ok);
        check("rsp_dat", rsp_dat, (ok && !we) ? rd : 32'h0);
        check("beat_count", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("beat%0d", i), got_q[i], exp_q[i]);

        if (ok) begin
            ctx_valid = 1'b1; ctx_we = we; ctx_adr = adr;
        end else begin
            ctx_valid = 1'b0;
        end

        @(negedge limb_clk);
        check("rsp_pulse_end", rsp_valid, 1'b0);
        check("idle_ready", cmd_ready, 1'b1);
    endtask

    initial begin
        bit          r_we;
        logic [35:0] r_adr;
        int          r_nw, sel;

        reset = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = 36'h0; cmd_dat = 32'h0;
        limb_d_in = 8'h00; limb_nwait = 1'b1;
        repeat (3) @(negedge limb_clk);
        check_reset_outputs("reset_state");
        reset = 1'b0;
        @(negedge limb_clk);
        check_reset_outputs("idle_after_reset");

        xact(1'b1, 36'h9_1234_5678, 32'hDEADBEEF, 32'h0, 0, 1'b0, 0, 1'b0);
        xact(1'b0, 36'h0_0000_0010, 32'h0, 32'hCAFEF00D, 0, 1'b0, 0, 1'b0);
        xact(1'b1, 36'h3_0000_4000, 32'h1122_3344, 32'h0, 50, 1'b0, 0, 1'b0);
        xact(1'b0, 36'h3_0000_5000, 32'h0, 32'h5566_7788, TO - 3, 1'b0, 0, 1'b0);
        xact(1'b1, 36'h3_0000_6000, 32'hA5A5_5A5A, 32'h0, TO - 2, 1'b0, 0, 1'b0);
        xact(1'b1, 36'h3_0000_6001, 32'h0102_0304, 32'h0, 0, 1'b0, 0, 1'b0);
        xact(1'b0, 36'h3_0000_7000, 32'h0, 32'h9999_0000, 200, 1'b0, 0, 1'b0);
        xact(1'b1, 36'h7_ABCD_EF00, 32'h7777_8888, 32'h0, 0, 1'b0, 0, 1'b0);
        xact(1'b1, 36'h7_ABCD_EF01, 32'h0BAD_F00D, 32'h0, 0, 1'b0, 8, 1'b0);
        xact(1'b1, 36'h7_ABCD_EF02, 32'h1357_9BDF, 32'h0, 0, 1'b0, 0, 1'b0);

        nxt_we = 1'b0; nxt_adr = 36'h2_2222_2200; nxt_dat = 32'h0;
        xact(1'b1, 36'h1_1111_1100, 32'hFEED_FACE, 32'h0, 3, 1'b1, 0, 1'b0);
        xact(1'b0, 36'h2_2222_2200, 32'h0, 32'h2468_ACE0, 2, 1'b0, 0, 1'b1);

        xact(1'b1, 36'h5_0000_00FE, 32'h0000_00FE, 32'h0, 0, 1'b0, 0, 1'b0);
        xact(1'b1, 36'h5_0000_00FF, 32'h0000_00FF, 32'h0, 0, 1'b0, 0, 1'b0);
        xact(1'b1, 36'h5_0000_0100, 32'h0000_0100, 32'h0, 0, 1'b0, 0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 2);
            if (sel == 0) begin
                r_we  = ctx_we;
                r_adr = ctx_adr + 36'd1;
            end else begin
                r_we  = 1'($urandom_range(0, 1));
                r_adr[35:32] = 4'($urandom_range(0, 15));
                r_adr[31:0]  = $urandom;
            end
            sel = $urandom_range(0, 9);
            if (sel < 6)       r_nw = sel;
            else if (sel < 8)  r_nw = $urandom_range(6, 20);
            else if (sel == 8) r_nw = TO - 2;
            else               r_nw = TO - 3;
            xact(r_we, r_adr, $urandom, $urandom, r_nw, 1'b0, 0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
